// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared lamp codes and FSM state type for the multi-way traffic light controller
package tlc_pkg;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1
`ifdef TLC_ALLRED_EN
        ,
        ST_ALLRED = 2'd2
`endif
    } tlc_state_t;

endpackage

// File: rtl/tlc_rr_pick.sv
// rtl/tlc_rr_pick.sv - combinational round-robin picker of the next approach to serve
module tlc_rr_pick #(
    parameter int N_APPROACH = 4,
    parameter int IDX_W      = $clog2(N_APPROACH)
) (
    input  logic [N_APPROACH-1:0] sensor,
    input  logic [IDX_W-1:0]      cur,
    output logic [IDX_W-1:0]      target,
    output logic                  valid
);

    logic found;
    int   j;

    // Nearest demanding approach after cur wins; otherwise fall back to home (0) unless already home.
    always_comb begin
        target = '0;
        found  = 1'b0;
        j      = 0;
        for (int d = 1; d < N_APPROACH; d++) begin
            j = (int'(cur) + d) % N_APPROACH;
            if (!found && sensor[j]) begin
                found  = 1'b1;
                target = IDX_W'(j);
            end
        end
        valid = found || (cur != '0);
    end

endmodule

// File: rtl/tlc_multiway.sv
// rtl/tlc_multiway.sv - N-approach round-robin traffic light controller; optional all-red clearance via TLC_ALLRED_EN
module tlc_multiway
    import tlc_pkg::*;
#(
    parameter int N_APPROACH = 4,
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 32,
    parameter int YELLOW_T   = 4,
    parameter int ALLRED_T   = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_APPROACH-1:0]         sensor,
    output logic [2*N_APPROACH-1:0]       lights,
    output logic [$clog2(N_APPROACH)-1:0] active,
    output logic                          phase_change
);

    localparam int IDX_W = $clog2(N_APPROACH);

    localparam logic [CNT_W-1:0] G_MIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_M1     = CNT_W'(YELLOW_T - 1);
`ifdef TLC_ALLRED_EN
    localparam logic [CNT_W-1:0] A_M1     = CNT_W'(ALLRED_T - 1);
`endif
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2*N_APPROACH-1:0] HOME_LIGHTS = {{(2*N_APPROACH-2){1'b0}}, LAMP_GREEN};

    // Reject parameter sets that would break the minimum-time guarantees.
    if (N_APPROACH < 2 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_params
        $error("tlc_multiway: illegal parameter set");
    end

    tlc_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] pick_target;
    logic             pick_valid;
    logic             leave_green;

    tlc_rr_pick #(
        .N_APPROACH (N_APPROACH),
        .IDX_W      (IDX_W)
    ) u_pick (
        .sensor (sensor),
        .cur    (active),
        .target (pick_target),
        .valid  (pick_valid)
    );

    // Green may end only after minimum time, with somewhere to go, and once own demand is gone or max time is hit.
    always_comb begin
        leave_green = (cnt >= G_MIN_M1) && pick_valid && (!sensor[active] || (cnt >= G_MAX_M1));
    end

    // Phase sequencer: owns state, timer, latched target and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_GREEN;
            cnt          <= '0;
            active       <= '0;
            next_idx     <= '0;
            phase_change <= 1'b0;
            lights       <= HOME_LIGHTS;
        end else begin
            phase_change <= 1'b0;
            case (state)
                ST_GREEN: begin
                    if (leave_green) begin
                        state                <= ST_YELLOW;
                        cnt                  <= '0;
                        next_idx             <= pick_target;
                        lights[2*active +: 2] <= LAMP_YELLOW;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_YELLOW: begin
                    if (cnt >= Y_M1) begin
                        cnt <= '0;
`ifdef TLC_ALLRED_EN
                        state  <= ST_ALLRED;
                        lights <= '0;
`else
                        state                   <= ST_GREEN;
                        active                  <= next_idx;
                        phase_change            <= 1'b1;
                        lights                  <= '0;
                        lights[2*next_idx +: 2] <= LAMP_GREEN;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef TLC_ALLRED_EN
                ST_ALLRED: begin
                    if (cnt >= A_M1) begin
                        state                   <= ST_GREEN;
                        cnt                     <= '0;
                        active                  <= next_idx;
                        phase_change            <= 1'b1;
                        lights                  <= '0;
                        lights[2*next_idx +: 2] <= LAMP_GREEN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif
                default: begin
                    state  <= ST_GREEN;
                    cnt    <= '0;
                    active <= '0;
                    lights <= HOME_LIGHTS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlc_multiway.sv
// tb/tb_tlc_multiway.sv - randomized self-checking bench for tlc_multiway against a phase-level reference model
module tb_tlc_multiway;

    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int GMIN = 8;
    localparam int GMAX = 32;
    localparam int YT   = 4;
    localparam int AT   = 2;
`ifdef TLC_ALLRED_EN
    localparam bit ALLRED = 1'b1;
`else
    localparam bit ALLRED = 1'b0;
`endif
    localparam int FIRST_PC = GMIN + YT + (ALLRED ? AT : 0);

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   sensor = '0;
    logic [2*N-1:0] lights;
    logic [1:0]     active;
    logic           phase_change;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0 green, 1 yellow, 2 all-red; age = cycles already spent in phase
    int m_phase, m_act, m_age, m_tgt;
    bit m_pc;

    always #5 clock = ~clock;

    tlc_multiway #(
        .N_APPROACH (N),
        .CNT_W      (CW),
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .YELLOW_T   (YT),
        .ALLRED_T   (AT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sensor       (sensor),
        .lights       (lights),
        .active       (active),
        .phase_change (phase_change)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int k, input logic [N-1:0] s);
        for (int d = 1; d < N; d++) begin
            if (s[(k + d) % N]) return (k + d) % N;
        end
        return (k != 0) ? 0 : -1;
    endfunction

    function automatic logic [2*N-1:0] exp_lights();
        logic [2*N-1:0] v;
        v = '0;
        if (m_phase == 0) v[2*m_act +: 2] = 2'b10;
        if (m_phase == 1) v[2*m_act +: 2] = 2'b01;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_act = 0; m_age = 0; m_tgt = 0; m_pc = 1'b0;
    endtask

    task automatic model_green();
        m_phase = 0; m_act = m_tgt; m_age = 0; m_pc = 1'b1;
    endtask

    task automatic model_edge(input logic [N-1:0] s);
        int t;
        m_pc = 1'b0;
        if (m_phase == 0) begin
            t = pick(m_act, s);
            if (m_age + 1 >= GMIN && t >= 0 && (!s[m_act] || m_age + 1 >= GMAX)) begin
                m_tgt = t; m_phase = 1; m_age = 0;
            end else if (m_age < 1000) begin
                m_age++;
            end
        end else if (m_phase == 1) begin
            if (m_age + 1 == YT) begin
                if (ALLRED) begin m_phase = 2; m_age = 0; end
                else model_green();
            end else m_age++;
        end else begin
            if (m_age + 1 == AT) model_green();
            else m_age++;
        end
    endtask

    task automatic compare_all();
        int nonred;
        int bad;
        nonred = 0; bad = 0;
        for (int i = 0; i < N; i++) begin
            if (lights[2*i +: 2] != 2'b00) nonred++;
            if (lights[2*i +: 2] == 2'b11) bad++;
        end
        check_eq("lights", 32'(lights), 32'(exp_lights()));
        check_eq("active", 32'(active), 32'(m_act));
        check_eq("phase_change", 32'(phase_change), 32'(m_pc));
        check_eq("one_nonred", 32'(nonred <= 1), 32'd1);
        check_eq("no_code11", 32'(bad), 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) model_reset();
        else model_edge(sensor);
        #1;
        compare_all();
    endtask

    // called right after step(): asserts reset between edges and checks it takes effect before the next edge
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        int first_pc;
        int first_y;
        bit saw2, reached3, reached0, hit;
        int hold;

        // reset state
        model_reset();
        @(posedge clock);
        #1;
        compare_all();
        check_eq("reset_lights", 32'(lights), 32'h02);
        reset = 1'b1;

        // idle home rest
        sensor = '0;
        for (int i = 0; i < 100; i++) step();
        check_eq("idle_lights", 32'(lights), 32'h02);

        // single side demand: exact latency to new green on approach 2
        async_reset();
        sensor = 4'b0100;
        first_pc = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (phase_change && first_pc < 0) first_pc = i;
        end
        check_eq("s2_first_pc", 32'(first_pc), 32'(FIRST_PC));
        check_eq("s2_active", 32'(active), 32'd2);

        // home demand held with competing demand: max green
        async_reset();
        sensor = 4'b0011;
        first_y = -1;
        for (int i = 1; i <= 150; i++) begin
            step();
            if (lights[1:0] == 2'b01 && first_y < 0) first_y = i;
        end
        check_eq("s3_max_green", 32'(first_y), 32'(GMAX));

        // skip approach 2, then return home
        async_reset();
        sensor = 4'b0010;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            if (active == 2'd1 && lights[3:2] == 2'b10) hit = 1'b1;
        end
        check_eq("s4_reach1", 32'(hit), 32'd1);
        sensor = 4'b1010;
        saw2 = 1'b0; reached3 = 1'b0;
        for (int i = 0; i < 200 && !reached3; i++) begin
            step();
            if (active == 2'd2) saw2 = 1'b1;
            if (active == 2'd3 && lights[7:6] == 2'b10) reached3 = 1'b1;
        end
        check_eq("s4_reach3", 32'(reached3), 32'd1);
        check_eq("s4_skip2", 32'(saw2), 32'd0);
        sensor = 4'b0000;
        reached0 = 1'b0;
        for (int i = 0; i < 100 && !reached0; i++) begin
            step();
            if (active == 2'd0 && lights == 8'h02) reached0 = 1'b1;
        end
        check_eq("s4_home", 32'(reached0), 32'd1);

        // reset asserted in the middle of yellow
        sensor = 4'b0010;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            if (lights[1:0] == 2'b01) hit = 1'b1;
        end
        check_eq("s5_reach_yellow", 32'(hit), 32'd1);
        step();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("s5_async_lights", 32'(lights), 32'h02);
        check_eq("s5_async_active", 32'(active), 32'd0);
        compare_all();
        @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;

        // randomized sensor traffic with occasional async reset
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                sensor = N'($urandom);
                hold = $urandom_range(1, 40);
            end
            hold--;
            step();
            if ($urandom_range(0, 599) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
